// File: rtl/mm_pkg.sv
// Shared helpers for the matrix accumulate datapath: width arithmetic and
// signed saturation used when narrowing accumulator results.
package mm_pkg;

   // Widest value the saturation helper accepts
   localparam int unsigned SatW = 128;

   typedef logic signed [SatW-1:0] wide_t;

   typedef struct packed {
      logic  clip;
      wide_t value;
   } sat_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned p;
      r = 0;
      p = 1;
      while (p < v) begin
         p = p << 1;
         r++;
      end
      return r;
   endfunction

   // Headroom for N full-width products plus 8 guard bits for multi-tile groups
   function automatic int unsigned acc_w_default(input int unsigned dw, input int unsigned n);
      return 2 * dw + clog2(n) + 8;
   endfunction

   // Clamp v into the signed dw-bit range and report whether it was clipped
   function automatic sat_t saturate(input wide_t v, input int unsigned dw);
      sat_t  r;
      wide_t hi;
      wide_t lo;
      hi      = (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
      lo      = ~hi;
      r.clip  = 1'b0;
      r.value = v;
      if (v > hi) begin
         r.clip  = 1'b1;
         r.value = hi;
      end else if (v < lo) begin
         r.clip  = 1'b1;
         r.value = lo;
      end
      return r;
   endfunction

endpackage

// File: rtl/matrix_acc_engine_if.sv
// Beat input stream and result output stream of the matrix accumulate engine.
interface matrix_acc_engine_if #(
   parameter int unsigned M   = 16,
   parameter int unsigned N   = 16,
   parameter int unsigned DW  = 32,
   parameter int unsigned TCW = 16
);

   logic [DW*M*N-1:0] in_matrix;
   logic [DW*N-1:0]   in_vector;
   logic              in_last;
   logic              in_valid;
   logic              in_ready;
   logic [DW*M-1:0]   out_data;
   logic [M-1:0]      out_sat;
   logic [TCW-1:0]    out_tiles;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output in_matrix, in_vector, in_last, in_valid, out_ready,
      input  in_ready, out_data, out_sat, out_tiles, out_valid
   );

   modport slave (
      input  in_matrix, in_vector, in_last, in_valid, out_ready,
      output in_ready, out_data, out_sat, out_tiles, out_valid
   );

endinterface

// File: rtl/matrix_row_dot.sv
// One output row: N signed multipliers (S1 register) feeding a balanced
// adder tree (S2 register). Both stages advance only when en_i is high.
module matrix_row_dot
   import mm_pkg::*;
#(
   parameter int unsigned N     = 16,
   parameter int unsigned DW    = 32,
   parameter int unsigned ACC_W = acc_w_default(DW, N)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en_i,
   input  logic [N*DW-1:0]         row_i,
   input  logic [N*DW-1:0]         vec_i,
   output logic signed [ACC_W-1:0] sum_o
);

   localparam int unsigned PW = 2 * DW;
   // Leaf count rounded up to a power of two so the tree is uniform
   localparam int unsigned NP = 1 << clog2(N);

   logic signed [PW-1:0]    prod_d [N];
   logic signed [PW-1:0]    prod_q [N];
   logic signed [ACC_W-1:0] tree   [2*NP-1];
   logic signed [ACC_W-1:0] sum_q;

   // Full-precision signed products, one per column
   always_comb begin
      for (int n = 0; n < N; n++) begin
         prod_d[n] = PW'($signed(row_i[n*DW +: DW])) * PW'($signed(vec_i[n*DW +: DW]));
      end
   end

   // S1: product register
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int n = 0; n < N; n++) begin
            prod_q[n] <= '0;
         end
      end else if (en_i) begin
         prod_q <= prod_d;
      end
   end

   // Heap-ordered adder tree: leaves at NP-1.., node i sums children 2i+1 and 2i+2
   always_comb begin
      for (int i = 0; i < 2 * NP - 1; i++) begin
         tree[i] = '0;
      end
      for (int i = 0; i < N; i++) begin
         tree[NP-1+i] = {{(ACC_W-PW){prod_q[i][PW-1]}}, prod_q[i]};
      end
      for (int i = NP - 2; i >= 0; i--) begin
         tree[i] = tree[2*i+1] + tree[2*i+2];
      end
   end

   // S2: row sum register
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_q <= '0;
      end else if (en_i) begin
         sum_q <= tree[0];
      end
   end

   assign sum_o = sum_q;

endmodule

// File: rtl/matrix_acc_engine.sv
// M x N signed matrix-vector multiply-accumulate. Row dot products are summed
// across beats until a last beat, then shifted, saturated and held on a
// valid/ready output. The whole pipeline stalls while a result waits.
module matrix_acc_engine
   import mm_pkg::*;
#(
   parameter int unsigned M     = 16,
   parameter int unsigned N     = 16,
   parameter int unsigned DW    = 32,
   parameter int unsigned ACC_W = acc_w_default(DW, N),
   parameter int unsigned SHIFT = 0,
   parameter int unsigned TCW   = 16
) (
   input logic                clk,
   input logic                rst,
   matrix_acc_engine_if.slave bus_io
);

   logic en;

   logic s1_valid_q, s1_last_q;
   logic s2_valid_q, s2_last_q;

   logic signed [ACC_W-1:0] row_sum   [M];
   logic signed [ACC_W-1:0] acc_q     [M];
   logic signed [ACC_W-1:0] acc_d     [M];
   logic signed [ACC_W-1:0] acc_sum   [M];
   logic signed [ACC_W-1:0] acc_shift [M];
   logic [DW:0]             clamp     [M];

   logic [TCW-1:0] cnt_q, cnt_d, cnt_inc;

   logic [DW-1:0]  out_data_q [M];
   logic [DW-1:0]  out_data_d [M];
   logic [M-1:0]   out_sat_q, out_sat_d;
   logic [TCW-1:0] out_tiles_q, out_tiles_d;
   logic           out_valid_q, out_valid_d;

   // {clip, narrowed value} for one shifted row total
   function automatic logic [DW:0] clamp_row(input logic signed [ACC_W-1:0] v);
      sat_t s;
      s = saturate(wide_t'(v), DW);
      return {s.clip, s.value[DW-1:0]};
   endfunction

   // A held, unconsumed result freezes every stage
   assign en              = !out_valid_q || bus_io.out_ready;
   assign bus_io.in_ready = en && !rst;

   for (genvar m = 0; m < M; m++) begin : g_row
      matrix_row_dot #(
         .N     (N),
         .DW    (DW),
         .ACC_W (ACC_W)
      ) u_row (
         .clk   (clk),
         .rst   (rst),
         .en_i  (en),
         .row_i (bus_io.in_matrix[m*N*DW +: N*DW]),
         .vec_i (bus_io.in_vector),
         .sum_o (row_sum[m])
      );

      assign acc_sum[m]                   = acc_q[m] + row_sum[m];
      assign acc_shift[m]                 = acc_sum[m] >>> SHIFT;
      assign clamp[m]                     = clamp_row(acc_shift[m]);
      assign bus_io.out_data[m*DW +: DW]  = out_data_q[m];
   end

   assign cnt_inc = (cnt_q == {TCW{1'b1}}) ? cnt_q : cnt_q + TCW'(1);

   // Valid/last bits travel alongside the S1/S2 data
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_last_q  <= 1'b0;
      end else if (en) begin
         s1_valid_q <= bus_io.in_valid;
         s1_last_q  <= bus_io.in_last;
         s2_valid_q <= s1_valid_q;
         s2_last_q  <= s1_last_q;
      end
   end

   // S3: accumulate non-last beats; a last beat publishes and restarts the group
   always_comb begin
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_sat_d   = out_sat_q;
      out_tiles_d = out_tiles_q;
      out_valid_d = out_valid_q;
      if (en) begin
         out_valid_d = 1'b0;
         if (s2_valid_q && s2_last_q) begin
            for (int m = 0; m < M; m++) begin
               acc_d[m]      = '0;
               out_data_d[m] = clamp[m][DW-1:0];
               out_sat_d[m]  = clamp[m][DW];
            end
            cnt_d       = '0;
            out_tiles_d = cnt_inc;
            out_valid_d = 1'b1;
         end else if (s2_valid_q) begin
            acc_d = acc_sum;
            cnt_d = cnt_inc;
         end
      end
   end

   // S3 state and output register
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int m = 0; m < M; m++) begin
            acc_q[m]      <= '0;
            out_data_q[m] <= '0;
         end
         cnt_q       <= '0;
         out_sat_q   <= '0;
         out_tiles_q <= '0;
         out_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_sat_q   <= out_sat_d;
         out_tiles_q <= out_tiles_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus_io.out_sat   = out_sat_q;
   assign bus_io.out_tiles = out_tiles_q;
   assign bus_io.out_valid = out_valid_q;

endmodule

// File: tb/tb_matrix_acc_engine.sv
// Bench for matrix_acc_engine: two instances (SHIFT=0 and SHIFT=4) driven with
// identical beats, checked against an arithmetic reference model.
module tb_matrix_acc_engine;

   localparam int unsigned M   = 4;
   localparam int unsigned N   = 4;
   localparam int unsigned DW  = 16;
   localparam int unsigned TCW = 16;

   typedef struct packed {
      logic [M*DW-1:0] data;
      logic [M-1:0]    sat;
      logic [TCW-1:0]  tiles;
   } res_t;

   logic clk = 1'b0;
   logic rst;

   logic [M*N*DW-1:0] mat_v;
   logic [N*DW-1:0]   vec_v;
   logic              vld_v, last_v, rdy_v;

   int n_checks = 0;
   int n_fail   = 0;
   int held_cnt = 0;
   int n_out0   = 0;
   int n_out4   = 0;

   longint acc_m [M];
   int     cnt_m;
   res_t   q0[$];
   res_t   q4[$];

   always #5 clk = ~clk;

   matrix_acc_engine_if #(.M(M), .N(N), .DW(DW), .TCW(TCW)) bus0 ();
   matrix_acc_engine_if #(.M(M), .N(N), .DW(DW), .TCW(TCW)) bus4 ();

   assign bus0.in_matrix = mat_v;
   assign bus0.in_vector = vec_v;
   assign bus0.in_valid  = vld_v;
   assign bus0.in_last   = last_v;
   assign bus0.out_ready = rdy_v;
   assign bus4.in_matrix = mat_v;
   assign bus4.in_vector = vec_v;
   assign bus4.in_valid  = vld_v;
   assign bus4.in_last   = last_v;
   assign bus4.out_ready = rdy_v;

   matrix_acc_engine #(.M(M), .N(N), .DW(DW), .SHIFT(0), .TCW(TCW)) u_dut0 (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus0)
   );

   matrix_acc_engine #(.M(M), .N(N), .DW(DW), .SHIFT(4), .TCW(TCW)) u_dut4 (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus4)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic longint sx(input logic [DW-1:0] v);
      return longint'($signed(v));
   endfunction

   // Clamp the model accumulators after an arithmetic shift
   function automatic res_t model_result(input int sh);
      res_t   r;
      longint v, hi, lo;
      hi = (longint'(1) << (DW - 1)) - 1;
      lo = -hi - 1;
      for (int m = 0; m < M; m++) begin
         v = acc_m[m] >>> sh;
         r.sat[m] = 1'b0;
         if (v > hi) begin
            v = hi;
            r.sat[m] = 1'b1;
         end else if (v < lo) begin
            v = lo;
            r.sat[m] = 1'b1;
         end
         r.data[m*DW +: DW] = v[DW-1:0];
      end
      r.tiles = (cnt_m > (1 << TCW) - 1) ? {TCW{1'b1}} : cnt_m[TCW-1:0];
      return r;
   endfunction

   task automatic model_clear();
      for (int m = 0; m < M; m++) acc_m[m] = 0;
      cnt_m = 0;
   endtask

   task automatic model_accept();
      longint s;
      for (int m = 0; m < M; m++) begin
         s = 0;
         for (int n = 0; n < N; n++) begin
            s += sx(mat_v[(m*N+n)*DW +: DW]) * sx(vec_v[n*DW +: DW]);
         end
         acc_m[m] += s;
      end
      cnt_m++;
      if (last_v) begin
         q0.push_back(model_result(0));
         q4.push_back(model_result(4));
         model_clear();
      end
   endtask

   // Any shown result must equal the oldest expected one, every cycle it is shown
   task automatic mon(input bit is4, input logic ov, input logic [M*DW-1:0] od,
                      input logic [M-1:0] os, input logic [TCW-1:0] ot, input logic ir);
      res_t e;
      if (!ov) return;
      if (!rdy_v) begin
         check_eq(is4 ? "in_ready_held4" : "in_ready_held0", 64'(ir), 64'(0));
         held_cnt++;
      end
      if ((is4 ? q4.size() : q0.size()) == 0) begin
         check_eq(is4 ? "unexpected_out4" : "unexpected_out0", 64'(ov), 64'(0));
         return;
      end
      e = is4 ? q4[0] : q0[0];
      check_eq(is4 ? "out_data4" : "out_data0", 64'(od), 64'(e.data));
      check_eq(is4 ? "out_sat4" : "out_sat0", 64'(os), 64'(e.sat));
      check_eq(is4 ? "out_tiles4" : "out_tiles0", 64'(ot), 64'(e.tiles));
      if (rdy_v) begin
         if (is4) begin
            void'(q4.pop_front());
            n_out4++;
         end else begin
            void'(q0.pop_front());
            n_out0++;
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         model_clear();
         check_eq("rst_in_ready0", 64'(bus0.in_ready), 64'(0));
         check_eq("rst_in_ready4", 64'(bus4.in_ready), 64'(0));
      end else begin
         if (vld_v && bus0.in_ready) model_accept();
         mon(1'b0, bus0.out_valid, bus0.out_data, bus0.out_sat, bus0.out_tiles, bus0.in_ready);
         mon(1'b1, bus4.out_valid, bus4.out_data, bus4.out_sat, bus4.out_tiles, bus4.in_ready);
      end
   end

   // Caller is at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send_beat(input logic [M*N*DW-1:0] mat, input logic [N*DW-1:0] vec,
                            input logic last);
      bit acc;
      mat_v  = mat;
      vec_v  = vec;
      last_v = last;
      vld_v  = 1'b1;
      acc    = 1'b0;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk);
         acc = bus0.in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) check_eq("accept_timeout", 64'(acc), 64'(1));
      vld_v  = 1'b0;
      last_v = 1'b0;
   endtask

   task automatic drain();
      int i;
      i = 0;
      while ((q0.size() != 0 || q4.size() != 0) && i < 300) begin
         @(posedge clk);
         #1;
         i++;
      end
      check_eq("drain_pending", 64'(q0.size() + q4.size()), 64'(0));
   endtask

   function automatic logic [M*N*DW-1:0] fill_mat(input logic [DW-1:0] v);
      logic [M*N*DW-1:0] r;
      for (int i = 0; i < M * N; i++) r[i*DW +: DW] = v;
      return r;
   endfunction

   function automatic logic [N*DW-1:0] fill_vec(input logic [DW-1:0] v);
      logic [N*DW-1:0] r;
      for (int i = 0; i < N; i++) r[i*DW +: DW] = v;
      return r;
   endfunction

   function automatic logic [DW-1:0] rand_elem(input bit full);
      logic [DW-1:0] t;
      t = full ? DW'($urandom) : DW'($urandom_range(0, 15)) - DW'(8);
      return t;
   endfunction

   initial begin
      logic [M*N*DW-1:0] ident, shm, rm;
      logic [N*DW-1:0]   xv, sv, rv;
      int                base0, base4;
      bit                done;
      bit                full;

      rst    = 1'b1;
      vld_v  = 1'b0;
      last_v = 1'b0;
      mat_v  = '0;
      vec_v  = '0;
      rdy_v  = 1'b1;
      model_clear();

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_eq("rst_out_valid", 64'(bus0.out_valid), 64'(0));
      check_eq("rst_out_data", 64'(bus0.out_data), 64'(0));
      check_eq("rst_out_sat", 64'(bus0.out_sat), 64'(0));
      check_eq("rst_out_tiles", 64'(bus0.out_tiles), 64'(0));
      check_eq("rst_out_valid4", 64'(bus4.out_valid), 64'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("in_ready_after_rst", 64'(bus0.in_ready), 64'(1));
      @(posedge clk);
      #1;

      // Identity, single beat, latency e+2
      ident = '0;
      for (int m = 0; m < M; m++) ident[(m*N+m)*DW +: DW] = DW'(1);
      xv = {16'hFFFC, 16'h0003, 16'hFFFE, 16'h0001};
      send_beat(ident, xv, 1'b1);
      @(negedge clk);
      check_eq("lat_e", 64'(bus0.out_valid), 64'(0));
      @(negedge clk);
      check_eq("lat_e1", 64'(bus0.out_valid), 64'(0));
      @(negedge clk);
      check_eq("lat_e2", 64'(bus0.out_valid), 64'(1));
      check_eq("ident_data", 64'(bus0.out_data), 64'hFFFC_0003_FFFE_0001);
      check_eq("ident_tiles", 64'(bus0.out_tiles), 64'(1));
      @(posedge clk);
      #1;
      drain();

      // Three-beat group then a back-to-back single-beat group
      for (int b = 0; b < 3; b++) send_beat(fill_mat(16'd1), fill_vec(16'd2), b == 2);
      send_beat(fill_mat(16'd1), fill_vec(16'd2), 1'b1);
      drain();

      // Positive and negative saturation
      send_beat(fill_mat(16'h7FFF), fill_vec(16'h7FFF), 1'b1);
      send_beat(fill_mat(16'h7FFF), fill_vec(16'h8001), 1'b1);
      drain();

      // Row sum -33: floor shift gives -3 on the SHIFT=4 instance
      shm = '0;
      for (int m = 0; m < M; m++) shm[(m*N)*DW +: DW] = -DW'(33);
      sv = '0;
      sv[0 +: DW] = DW'(1);
      send_beat(shm, sv, 1'b1);
      drain();

      // Back-pressure: out_ready low for 5 cycles while 4 single-beat groups stream
      base0    = n_out0;
      base4    = n_out4;
      held_cnt = 0;
      rdy_v    = 1'b0;
      fork
         begin
            repeat (5) @(posedge clk);
            #1 rdy_v = 1'b1;
         end
         begin
            for (int g = 0; g < 4; g++) begin
               for (int i = 0; i < M * N; i++) rm[i*DW +: DW] = rand_elem(1'b0);
               for (int i = 0; i < N; i++) rv[i*DW +: DW] = rand_elem(1'b0);
               send_beat(rm, rv, 1'b1);
            end
         end
      join
      drain();
      check_eq("hold_observed", 64'(held_cnt >= 4), 64'(1));
      check_eq("hold_count0", 64'(n_out0 - base0), 64'(4));
      check_eq("hold_count4", 64'(n_out4 - base4), 64'(4));

      // Reset mid-group discards partial sums
      base0 = n_out0;
      send_beat(fill_mat(16'd3), fill_vec(16'd5), 1'b0);
      send_beat(fill_mat(16'd3), fill_vec(16'd5), 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      send_beat(ident, xv, 1'b1);
      drain();
      check_eq("rst_group_count", 64'(n_out0 - base0), 64'(1));

      // Randomized beats, group lengths and back-pressure
      done = 1'b0;
      fork
         begin
            for (int b = 0; b < 150; b++) begin
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end else begin
                  full = ($urandom_range(0, 1) == 1);
                  for (int i = 0; i < M * N; i++) rm[i*DW +: DW] = rand_elem(full);
                  for (int i = 0; i < N; i++) rv[i*DW +: DW] = rand_elem(full);
                  send_beat(rm, rv, (b == 149) || ($urandom_range(0, 2) == 0));
               end
            end
            if (cnt_m != 0) send_beat(fill_mat(16'd1), fill_vec(16'd1), 1'b1);
            done = 1'b1;
         end
         begin
            while (!done) begin
               rdy_v = ($urandom_range(0, 2) != 0);
               @(posedge clk);
               #1;
            end
            rdy_v = 1'b1;
         end
      join
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule
